alu8_reg: RTL and testbench



---
 rtl/alu8_pkg.sv | 17 +
 rtl/ripple_adder_8bit.sv | 16 +
 rtl/alu8_reg.sv | 66 ++++++
 tb/tb_alu8_reg.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// alu8_pkg: op codes and flag bundle shared by the registered 8-bit ALU
package alu8_pkg;
  localparam int ALU_W = 8;
  localparam logic [2:0] ALU_PASSTHROUGH = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_NOT = 3'd6;
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic sign;
  } alu_flags_t;
endpackage

// File: rtl/ripple_adder_8bit.sv
// ripple_adder_8bit: 8-bit sum as a chain of full adders
module ripple_adder_8bit (
  output logic [7:0] sum,
  output logic       carry_out,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in
);
  logic [8:0] c;
  assign c[0] = carry_in;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign carry_out = c[8];
endmodule

// File: rtl/alu8_reg.sv
// alu8_reg: registered pass/add/sub ALU with flags; ALU8_LOGIC_OPS_EN enables ops 3..6 (and/or/xor/not)
module alu8_reg
  import alu8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic       valid_out,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry,
  output logic       overflow,
  output logic       sign
);
  logic [7:0] add_sum, sub_sum, res;
  logic       add_co, sub_co, c, ov;
  alu_flags_t flags_d, flags_q;
  ripple_adder_8bit u_add (.sum(add_sum), .carry_out(add_co), .a(a), .b(b), .carry_in(1'b0));
  ripple_adder_8bit u_sub (.sum(sub_sum), .carry_out(sub_co), .a(a), .b(~b), .carry_in(1'b1));
  always_comb begin
    res = '0;
    c = 1'b0;
    ov = 1'b0;
    case (op)
      ALU_PASSTHROUGH: res = b;
      ALU_ADD: begin
        res = add_sum;
        c = add_co;
        ov = (a[7] == b[7]) & (add_sum[7] != a[7]);
      end
      ALU_SUB: begin
        res = sub_sum;
        c = sub_co;
        ov = (a[7] == ~b[7]) & (sub_sum[7] != a[7]);
      end
`ifdef ALU8_LOGIC_OPS_EN
      ALU_AND: res = a & b;
      ALU_OR: res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOT: res = ~a;
`endif
      default: res = '0;
    endcase
    flags_d = '{zero: (res == '0), carry: c, overflow: ov, sign: res[7]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      result <= '0;
      flags_q <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result <= res;
        flags_q <= flags_d;
      end
    end
  end
  assign zero = flags_q.zero;
  assign carry = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign sign = flags_q.sign;
endmodule

// File: tb/tb_alu8_reg.sv
// tb_alu8_reg: scoreboard bench for alu8_reg; define ALU8_LOGIC_OPS_EN to expect logic ops
module tb_alu8_reg;
  typedef struct packed {
    logic       v;
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;
  logic clk, rst_n, valid_in, valid_out, zero, carry, overflow, sign;
  logic [7:0] a, b, result;
  logic [2:0] op;
  exp_t sb_q[$];
  exp_t held;
  int n_cmp, n_bad;
  alu8_reg dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .op(op),
    .valid_out(valid_out), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .sign(sign)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int sx, sy, s;
    logic [8:0] w;
    sx = int'($signed(x));
    sy = int'($signed(y));
    e = '0;
    e.v = 1'b1;
    case (o)
      3'd0: e.r = y;
      3'd1: begin
        w = {1'b0, x} + {1'b0, y};
        e.r = w[7:0];
        e.f[2] = w[8];
        s = sx + sy;
        e.f[1] = (s > 127) || (s < -128);
      end
      3'd2: begin
        e.r = x - y;
        e.f[2] = (x >= y);
        s = sx - sy;
        e.f[1] = (s > 127) || (s < -128);
      end
`ifdef ALU8_LOGIC_OPS_EN
      3'd3: e.r = x & y;
      3'd4: e.r = x | y;
      3'd5: e.r = x ^ y;
      3'd6: e.r = ~x;
`endif
      default: e.r = 8'd0;
    endcase
    e.f[3] = (e.r == 8'd0);
    e.f[0] = e.r[7];
    return e;
  endfunction
  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    valid_in = v;
    op = o;
    a = x;
    b = y;
    if (v) held = model(o, x, y);
    else held.v = 1'b0;
    sb_q.push_back(held);
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("valid_out", {11'd0, valid_out}, {11'd0, e.v});
      check("result", {4'd0, result}, {4'd0, e.r});
      check("flags_zcos", {8'd0, zero, carry, overflow, sign}, {8'd0, e.f});
    end
  end
  task automatic check_reset(input string tag);
    check(tag, {3'd0, valid_out, result}, 12'd0);
    check({tag, "_flags"}, {8'd0, zero, carry, overflow, sign}, 12'd0);
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    held = '0;
    valid_in = 1'b0;
    op = 3'd0;
    a = 8'd0;
    b = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset("reset_init");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 3'd1, 8'd1, 8'd2);
    drive(1, 3'd1, 8'd255, 8'd1);
    drive(1, 3'd2, 8'd100, 8'd100);
    drive(1, 3'd1, 8'd120, 8'd11);
    drive(1, 3'd1, 8'd129, 8'd200);
    drive(1, 3'd2, 8'd7, 8'd128);
    drive(1, 3'd2, 8'd1, 8'd2);
    drive(1, 3'd0, 8'hFF, 8'h55);
    drive(1, 3'd3, 8'hF0, 8'h3C);
    drive(1, 3'd4, 8'hF0, 8'h3C);
    drive(1, 3'd5, 8'hF0, 8'h3C);
    drive(1, 3'd6, 8'hF0, 8'h3C);
    drive(1, 3'd7, 8'hF0, 8'h3C);
    drive(1, 3'd1, 8'h80, 8'h7F);
    for (int i = 0; i < 3; i++) drive(0, 3'd1, 8'd9, 8'd9);
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    drive(1, 3'd1, 8'd50, 8'd60);
    @(posedge clk);
    drive(1, 3'd2, 8'd3, 8'd200);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    sb_q.delete();
    held = '0;
    @(negedge clk) rst_n = 1'b1;
    drive(1, 3'd1, 8'd10, 8'd20);
    drive(0, 3'd0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", 12'(sb_q.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
